// File: rtl/mips_exec_pkg.sv
// Shared state encodings for the MIPS run/step/breakpoint sequencer.
package mips_exec_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_BRK  = 2'd3
    } exec_state_e;

    // States in which the prescaler runs and the core may be enabled.
    function automatic logic is_active(exec_state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer with optional stable-time debounce and a one-clk
// rising-edge pulse on the accepted level.
module btn_sync_edge #(
    parameter bit DEB_EN     = 1'b0,
    parameter int DEB_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1, s2, lvl_now, lvl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    generate
        if (DEB_EN && DEB_CYCLES > 1) begin : g_deb
            localparam int CW = $clog2(DEB_CYCLES + 1);
            logic [CW-1:0] cnt;
            logic          deb;

            // Any return to the accepted level restarts the stability window.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt <= '0;
                    deb <= 1'b0;
                end else if (s2 == deb) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                    deb <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            assign lvl_now = deb;
        end else begin : g_raw
            assign lvl_now = s2;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) lvl_q <= 1'b0;
        else       lvl_q <= lvl_now;
    end

    assign level = lvl_now;
    assign rise  = lvl_now & ~lvl_q;

endmodule

// File: rtl/mips_exec_ctrl.sv
// Run/step/breakpoint sequencer for the multi-cycle MIPS core.
// Optional step-button debounce: define MIPS_STEP_DEBOUNCE_EN.
module mips_exec_ctrl
    import mips_exec_pkg::*;
#(
    parameter int DIV        = 50_000_000,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16,
    parameter int DEB_CYCLES = 500_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode_run,
    input  logic               step_btn,
    input  logic               bp_en,
    input  logic [ADDR_W-1:0]  bp_addr,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               instr_start,
    output logic               cpu_en,
    output logic               halted,
    output logic               bp_hit,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   instr_count
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef MIPS_STEP_DEBOUNCE_EN
    localparam bit STEP_DEB = 1'b1;
`else
    localparam bit STEP_DEB = 1'b0;
`endif

    exec_state_e   state, state_nxt;
    logic [PW-1:0] presc;
    logic          skip, skip_nxt, first, first_nxt, en_nxt;
    logic          mode_lvl, run_rise, step_pulse, step_lvl_unused;
    logic          tick, boundary, bp_match, fetch;

    btn_sync_edge #(.DEB_EN(1'b0), .DEB_CYCLES(1)) u_run_sync (
        .clk(clk), .reset(reset), .din(mode_run),
        .level(mode_lvl), .rise(run_rise)
    );

    btn_sync_edge #(.DEB_EN(STEP_DEB), .DEB_CYCLES(DEB_CYCLES)) u_step_sync (
        .clk(clk), .reset(reset), .din(step_btn),
        .level(step_lvl_unused), .rise(step_pulse)
    );

    assign tick     = is_active(state) && (presc == PW'(DIV - 1));
    assign boundary = tick && instr_start;
    assign bp_match = bp_en && (pc == bp_addr);
    assign fetch    = cpu_en && instr_start;

    always_comb begin
        state_nxt = state;
        en_nxt    = 1'b0;
        first_nxt = first;
        skip_nxt  = skip;
        // The breakpoint skip only covers the instruction that tripped it.
        if (fetch) skip_nxt = 1'b0;
        unique case (state)
            ST_HALT: begin
                if (mode_lvl)        state_nxt = ST_RUN;
                else if (step_pulse) state_nxt = ST_STEP;
            end
            ST_RUN: begin
                if (tick) begin
                    if (boundary && !mode_lvl)               state_nxt = ST_HALT;
                    else if (boundary && bp_match && !skip)  state_nxt = ST_BRK;
                    else                                     en_nxt    = 1'b1;
                end
            end
            ST_STEP: begin
                if (tick) begin
                    if (boundary && first) begin
                        state_nxt = ST_HALT;
                    end else begin
                        en_nxt = 1'b1;
                        if (boundary) first_nxt = 1'b1;
                    end
                end
            end
            ST_BRK: begin
                if (run_rise) begin
                    state_nxt = ST_RUN;
                    skip_nxt  = 1'b1;
                end else if (step_pulse) begin
                    state_nxt = ST_STEP;
                    skip_nxt  = 1'b1;
                end
            end
        endcase
        if (state_nxt == ST_STEP && state != ST_STEP) first_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_HALT;
            presc       <= '0;
            skip        <= 1'b0;
            first       <= 1'b0;
            cpu_en      <= 1'b0;
            halted      <= 1'b1;
            bp_hit      <= 1'b0;
            instr_count <= '0;
        end else begin
            state  <= state_nxt;
            skip   <= skip_nxt;
            first  <= first_nxt;
            cpu_en <= en_nxt;
            halted <= (state_nxt == ST_HALT) || (state_nxt == ST_BRK);
            bp_hit <= (state_nxt == ST_BRK);
            // Held at zero outside RUN/STEP, so every entry starts a fresh period.
            if (!is_active(state) || tick) presc <= '0;
            else                           presc <= presc + 1'b1;
            if (fetch) instr_count <= instr_count + 1'b1;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Directed bench for mips_exec_ctrl with a stub 4-cycle FSM (pc += 4 per fetch).
module tb_mips_exec_ctrl;

    localparam int DIV = 4, ADDR_W = 32, CNT_W = 16, DEB = 8;

    logic              clk = 1'b0;
    logic              reset, mode_run, step_btn, bp_en;
    logic [ADDR_W-1:0] bp_addr, pc;
    logic              instr_start, cpu_en, halted, bp_hit;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  instr_count;
    logic [1:0]        phase;

    int checks = 0, errors = 0, pulse_cnt = 0;

    mips_exec_ctrl #(.DIV(DIV), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .mode_run(mode_run), .step_btn(step_btn),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr_start(instr_start),
        .cpu_en(cpu_en), .halted(halted), .bp_hit(bp_hit), .state_o(state_o),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Stub core: four enabled cycles per instruction, PC advances at fetch.
    assign instr_start = (phase == 2'd0);
    always @(posedge clk) begin
        if (reset) begin
            phase <= 2'd0;
            pc    <= '0;
        end else if (cpu_en) begin
            phase <= phase + 2'd1;
            if (phase == 2'd0) pc <= pc + 32'd4;
        end
    end

    always @(posedge clk) if (cpu_en) pulse_cnt <= pulse_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk); #1;
    endtask

    task automatic press(input int len);
        step_btn = 1'b1;
        repeat (len) clk1();
        step_btn = 1'b0;
    endtask

    // 0: idle; 1: wait to leave halted then return; 2: wait to return to halted.
    task automatic settle(input int mode);
        int n;
        if (mode == 1) begin
            n = 0;
            while (halted && n < 60) begin clk1(); n++; end
            check("leave_halted", halted, 1'b0);
        end
        if (mode >= 1) begin
            n = 0;
            while (!halted && n < 400) begin clk1(); n++; end
            check("reach_halted", halted, 1'b1);
        end
        repeat ((mode == 0) ? 40 : 30) clk1();
    endtask

    typedef struct {
        bit          mode;
        int          press_len;
        bit          bpe;
        logic [31:0] bpa;
        int          smode;
        int          exp_pulses;
        int          exp_count;
        logic [1:0]  exp_state;
        bit          exp_hit;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int p0, c0, n;
        vecs[0] = '{1'b0, 12, 1'b0, 32'h00, 1, 4,  1, 2'd0, 1'b0};
        vecs[1] = '{1'b0, 12, 1'b0, 32'h00, 1, 4,  2, 2'd0, 1'b0};
        vecs[2] = '{1'b1, 0,  1'b1, 32'h10, 1, 8,  4, 2'd3, 1'b1};
        vecs[3] = '{1'b0, 0,  1'b1, 32'h10, 0, 0,  4, 2'd3, 1'b1};
        vecs[4] = '{1'b0, 12, 1'b1, 32'h10, 1, 4,  5, 2'd0, 1'b0};
        vecs[5] = '{1'b1, 0,  1'b1, 32'h20, 1, 12, 8, 2'd3, 1'b1};
        vecs[6] = '{1'b0, 0,  1'b1, 32'h20, 0, 0,  8, 2'd3, 1'b1};

        reset = 1'b1; mode_run = 1'b0; step_btn = 1'b0; bp_en = 1'b0; bp_addr = '0;
        repeat (3) clk1();
        check("rst_cpu_en", cpu_en, 1'b0);
        check("rst_halted", halted, 1'b1);
        check("rst_bp_hit", bp_hit, 1'b0);
        check("rst_state", state_o, 2'd0);
        check("rst_count", instr_count, 0);

        // Free run: 64-clk window holds 16 enables and 4 fetches.
        reset = 1'b0; mode_run = 1'b1;
        n = 0;
        while (state_o != 2'd1 && n < 20) begin clk1(); n++; end
        check("run_entered", state_o, 2'd1);
        c0 = instr_count; p0 = 0;
        repeat (64) begin clk1(); if (cpu_en) p0++; end
        check("run_pulses", p0, 16);
        check("run_fetches", instr_count - c0, 4);

        // Reset in the middle of a run aborts on the next clk.
        reset = 1'b1;
        clk1();
        check("midrst_cpu_en", cpu_en, 1'b0);
        check("midrst_halted", halted, 1'b1);
        check("midrst_state", state_o, 2'd0);
        check("midrst_count", instr_count, 0);
        mode_run = 1'b0;
        clk1();
        reset = 1'b0;
        repeat (4) clk1();

        foreach (vecs[i]) begin
            mode_run = vecs[i].mode;
            bp_en    = vecs[i].bpe;
            bp_addr  = vecs[i].bpa;
            p0 = pulse_cnt;
            if (vecs[i].press_len > 0) press(vecs[i].press_len);
            settle(vecs[i].smode);
            check($sformatf("v%0d_pulses", i), pulse_cnt - p0, vecs[i].exp_pulses);
            check($sformatf("v%0d_count", i), instr_count, vecs[i].exp_count);
            check($sformatf("v%0d_state", i), state_o, vecs[i].exp_state);
            check($sformatf("v%0d_bp_hit", i), bp_hit, vecs[i].exp_hit);
        end

        // Resume from BRK at the breakpoint PC: it must execute once, then
        // mode_run drops one tick after that fetch.
        mode_run = 1'b1;
        n = 0;
        while (!(cpu_en && instr_start) && n < 100) begin @(negedge clk); n++; end
        check("skip_fetch_seen", cpu_en && instr_start, 1'b1);
        clk1();
        p0 = pulse_cnt;
        check("skip_count", instr_count, 9);
        repeat (3) clk1();
        mode_run = 1'b0;
        settle(2);
        check("drop_pulses", pulse_cnt - p0, 3);
        check("drop_count", instr_count, 9);
        check("drop_state", state_o, 2'd0);
        bp_en = 1'b0;

`ifdef MIPS_STEP_DEBOUNCE_EN
        p0 = pulse_cnt;
        press(5);
        settle(0);
        check("glitch_pulses", pulse_cnt - p0, 0);
        check("glitch_state", state_o, 2'd0);
        p0 = pulse_cnt; c0 = instr_count;
        press(12);
        settle(1);
        check("deb_step_pulses", pulse_cnt - p0, 4);
        check("deb_step_count", instr_count - c0, 1);
        check("deb_step_state", state_o, 2'd0);
`else
        // Run and step arriving together: run wins.
        mode_run = 1'b1;
        step_btn = 1'b1;
        repeat (3) clk1();
        step_btn = 1'b0;
        repeat (2) clk1();
        check("runwins_state", state_o, 2'd1);
        mode_run = 1'b0;
        settle(2);
        check("runwins_halt", state_o, 2'd0);

        // Second press while stepping is dropped, not queued.
        p0 = pulse_cnt; c0 = instr_count;
        press(3);
        repeat (5) clk1();
        press(3);
        settle(2);
        check("dbl_pulses", pulse_cnt - p0, 4);
        check("dbl_count", instr_count - c0, 1);
        check("dbl_state", state_o, 2'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
